// File: rtl/rbot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rbot_pkg
// Description : Shared constants and issue-FSM state type for the move queue
//               sequencer and its unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
package rbot_pkg;

    localparam int MOVE_W_DEF    = 4;
    localparam int SEQ_MOVES_DEF = 50;
    localparam int DEPTH_DEF     = 256;

    localparam int MOVE_NOP = 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/move_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : move_unpacker
// Description : Registers a packed move word and emits one nonzero move code
//               per cycle, MSB slot first; stops once the rest is all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module move_unpacker
    import rbot_pkg::*;
#(
    parameter int MOVE_W    = MOVE_W_DEF,
    parameter int SEQ_MOVES = SEQ_MOVES_DEF
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        abort,
    input  logic                        load_valid,
    input  logic [SEQ_MOVES*MOVE_W-1:0] load_seq,
    output logic                        load_ready,
    output logic                        push_valid,
    output logic [MOVE_W-1:0]           push_code
);

    localparam int SEQ_W = SEQ_MOVES * MOVE_W;

    logic             r_active;
    logic [SEQ_W-1:0] r_shift;
    logic [SEQ_W-1:0] w_rest;

    assign w_rest     = r_shift << MOVE_W;
    assign push_code  = r_shift[SEQ_W-1 -: MOVE_W];
    assign push_valid = r_active && (push_code != MOVE_W'(MOVE_NOP));
    assign load_ready = !r_active && !abort;

    // The all-zero test on the remaining bits also bounds a load to
    // SEQ_MOVES cycles: after the last slot the remainder is always zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_shift  <= '0;
        end else if (abort) begin
            r_active <= 1'b0;
        end else if (r_active) begin
            r_shift <= w_rest;
            if (w_rest == '0) begin
                r_active <= 1'b0;
            end
        end else if (load_valid) begin
            r_shift  <= load_seq;
            r_active <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/move_queue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : move_queue_sequencer
// Description : Circular move queue fed by the unpacker, drained one move at a
//               time to the executor over a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module move_queue_sequencer
    import rbot_pkg::*;
#(
    parameter int MOVE_W    = MOVE_W_DEF,
    parameter int SEQ_MOVES = SEQ_MOVES_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [SEQ_MOVES*MOVE_W-1:0] load_seq,
    input  logic                        run,
    input  logic                        abort,
    output logic [MOVE_W-1:0]           move_code,
    output logic                        move_start,
    input  logic                        move_done,
    output logic                        busy,
    output logic                        seq_done,
    output logic                        aborted,
    output logic [$clog2(DEPTH):0]      num_moves,
    output logic [15:0]                 curr_step,
    output logic                        overflow
);

    localparam int AW = $clog2(DEPTH);

    logic                push_valid;
    logic [MOVE_W-1:0]   push_code;

    logic [MOVE_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;

    seq_state_t          r_state;
    seq_state_t          w_state_next;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;

    move_unpacker #(
        .MOVE_W    (MOVE_W),
        .SEQ_MOVES (SEQ_MOVES)
    ) u_unpacker (
        .clock      (clock),
        .reset_n    (reset_n),
        .abort      (abort),
        .load_valid (load_valid),
        .load_seq   (load_seq),
        .load_ready (load_ready),
        .push_valid (push_valid),
        .push_code  (push_code)
    );

    // Fullness uses the registered count, so a same-cycle pop never makes
    // room for the push in that cycle.
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = push_valid && !w_full && !abort;
    assign w_drop  = push_valid &&  w_full && !abort;
    assign w_pop   = (r_state == ISSUE) && !abort;

    assign num_moves = r_count;
    assign busy      = (r_state != IDLE);
    assign seq_done  = (r_state == FINISH);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_code;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (run) w_state_next = w_empty ? FINISH : ISSUE;
            ISSUE:     w_state_next = WAIT_ACK;
            WAIT_ACK:  w_state_next = WAIT_DONE;
            WAIT_DONE: if (move_done) w_state_next = w_empty ? FINISH : ISSUE;
            FINISH:    w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
        if (abort) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            move_code  <= '0;
            move_start <= 1'b0;
            curr_step  <= '0;
            aborted    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            aborted <= abort;
            if (w_drop) begin
                overflow <= 1'b1;
            end
            if (abort) begin
                move_start <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (run && !w_empty) begin
                            curr_step <= '0;
                        end
                    end
                    ISSUE: begin
                        move_code  <= r_mem[r_rd_ptr];
                        move_start <= 1'b1;
                        curr_step  <= curr_step + 16'd1;
                    end
                    WAIT_ACK: move_start <= 1'b0;
                    FINISH:   move_code  <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_move_queue_sequencer.sv
`default_nettype none
// Bench for move_queue_sequencer: a queue-level reference model is compared
// against the DUT every cycle, plus directed scenarios with literal checks.
module tb_move_queue_sequencer;

    localparam int MW    = 4;
    localparam int SM    = 50;
    localparam int DEPTH = 4;
    localparam int SB    = MW * SM;
    localparam int NW    = $clog2(DEPTH) + 1;

    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_ACK = 2, PH_DONE = 3, PH_FIN = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_valid = 1'b0;
    logic [SB-1:0] load_seq = '0;
    logic          run = 1'b0;
    logic          abort = 1'b0;
    logic          move_done = 1'b0;
    logic          load_ready;
    logic [MW-1:0] move_code;
    logic          move_start;
    logic          busy;
    logic          seq_done;
    logic          aborted;
    logic [NW-1:0] num_moves;
    logic [15:0]   curr_step;
    logic          overflow;

    move_queue_sequencer #(.MOVE_W(MW), .SEQ_MOVES(SM), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .load_valid(load_valid),
        .load_ready(load_ready), .load_seq(load_seq), .run(run), .abort(abort),
        .move_code(move_code), .move_start(move_start), .move_done(move_done),
        .busy(busy), .seq_done(seq_done), .aborted(aborted),
        .num_moves(num_moves), .curr_step(curr_step), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [MW-1:0] m_q[$];
    logic [MW-1:0] m_slots[$];
    bit            m_unp = 0;
    bit            m_ovf = 0;
    int            m_phase = PH_IDLE;
    logic [MW-1:0] m_code = '0;
    bit            m_start = 0;
    logic [15:0]   m_step = '0;
    bit            m_abt = 0;

    always @(posedge clock or negedge reset_n) begin
        int n;
        int last;
        logic [MW-1:0] c;
        if (!reset_n) begin
            m_q.delete(); m_slots.delete();
            m_unp = 0; m_ovf = 0; m_phase = PH_IDLE;
            m_code = '0; m_start = 0; m_step = '0; m_abt = 0;
        end else if (abort) begin
            m_q.delete(); m_slots.delete();
            m_unp = 0; m_phase = PH_IDLE; m_abt = 1; m_start = 0;
        end else begin
            n = m_q.size();
            m_abt = 0;
            case (m_phase)
                PH_IDLE: if (run) begin
                    if (n > 0) begin m_step = '0; m_phase = PH_ISSUE; end
                    else m_phase = PH_FIN;
                end
                PH_ISSUE: begin
                    m_code = m_q.pop_front(); m_start = 1; m_step = m_step + 16'd1;
                    m_phase = PH_ACK;
                end
                PH_ACK:  begin m_start = 0; m_phase = PH_DONE; end
                PH_DONE: if (move_done) m_phase = (n > 0) ? PH_ISSUE : PH_FIN;
                default: begin m_code = '0; m_phase = PH_IDLE; end
            endcase
            if (m_unp) begin
                c = m_slots.pop_front();
                if (c != 0) begin
                    if (n < DEPTH) m_q.push_back(c);
                    else m_ovf = 1;
                end
                if (m_slots.size() == 0) m_unp = 0;
            end else if (load_valid) begin
                // examine slots up to the last nonzero one (at least one slot)
                last = 0;
                for (int i = 0; i < SM; i++)
                    if (load_seq[SB-1-i*MW -: MW] != 0) last = i;
                for (int i = 0; i <= last; i++) m_slots.push_back(load_seq[SB-1-i*MW -: MW]);
                m_unp = 1;
            end
        end
    end

    // ---------------- compare process ----------------
    logic [MW-1:0] log_q[$];
    int cnt_seq = 0, cnt_abt = 0, cnt_busy = 0, cnt_start = 0;

    always @(posedge clock) begin
        #1;
        chk("load_ready", load_ready, !m_unp && !abort);
        chk("busy",       busy,       m_phase != PH_IDLE);
        chk("move_start", move_start, m_start);
        chk("move_code",  move_code,  m_code);
        chk("seq_done",   seq_done,   m_phase == PH_FIN);
        chk("aborted",    aborted,    m_abt);
        chk("num_moves",  num_moves,  m_q.size());
        chk("curr_step",  curr_step,  m_step);
        chk("overflow",   overflow,   m_ovf);
        if (move_start) begin log_q.push_back(move_code); cnt_start++; end
        if (seq_done) cnt_seq++;
        if (aborted)  cnt_abt++;
        if (busy)     cnt_busy++;
    end

    // ---------------- executor ----------------
    int exec_dly = 2;
    int dly_cnt = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            move_done = 1'b0; dly_cnt = 0;
        end else if (move_start) begin
            move_done = 1'b0;
            dly_cnt = (exec_dly > 0) ? exec_dly : int'($urandom_range(1, 4));
        end else if (dly_cnt > 0) begin
            dly_cnt--;
            if (dly_cnt == 0) move_done = 1'b1;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [SB-1:0] pack(input logic [MW-1:0] c[$]);
        logic [SB-1:0] w = '0;
        for (int i = 0; i < SM; i++) begin
            w = w << MW;
            if (i < c.size()) w[MW-1:0] = c[i];
        end
        return w;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clr_stats();
        log_q.delete(); cnt_seq = 0; cnt_abt = 0; cnt_busy = 0; cnt_start = 0;
    endtask

    task automatic load(input logic [SB-1:0] w);
        int k = 0;
        while (!load_ready && k < 500) begin @(negedge clock); k++; end
        chk("load_wait_timeout", k >= 500, 0);
        load_valid = 1'b1; load_seq = w;
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1; @(negedge clock); run = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        @(negedge clock);
        while ((busy || !load_ready) && k < 2000) begin @(negedge clock); k++; end
        chk({name, "_idle_timeout"}, busy || !load_ready, 0);
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (log_q.size() < n && k < 500) begin @(negedge clock); k++; end
        chk("wait_log_timeout", log_q.size() < n, 0);
    endtask

    task automatic chk_log(input string name, input logic [MW-1:0] exp[$]);
        chk({name, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++) chk(name, log_q[i], exp[i]);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_load_ready"}, load_ready, 1);
        chk({name, "_busy"},       busy,       0);
        chk({name, "_move_start"}, move_start, 0);
        chk({name, "_move_code"},  move_code,  0);
        chk({name, "_num_moves"},  num_moves,  0);
        chk({name, "_curr_step"},  curr_step,  0);
        chk({name, "_overflow"},   overflow,   0);
        chk({name, "_seq_done"},   seq_done,   0);
        chk({name, "_aborted"},    aborted,    0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [SB-1:0] w;
        logic [MW-1:0] eq[$];
        logic [MW-1:0] cq[$];

        #12;
        chk_reset_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;
        cyc(2);

        // 3,A then zeros then 5
        clr_stats();
        w = '0; w[SB-1 -: MW] = 4'h3; w[SB-1-MW -: MW] = 4'hA; w[MW-1:0] = 4'h5;
        load(w); wait_idle("t1_load");
        pulse_run(); wait_idle("t1_run");
        eq = {4'h3, 4'hA, 4'h5};
        chk_log("t1_codes", eq);
        chk("t1_curr_step", curr_step, 3);
        chk("t1_num_moves", num_moves, 0);
        chk("t1_seq_done", cnt_seq, 1);

        // run on an empty queue
        clr_stats();
        pulse_run(); wait_idle("t2"); cyc(2);
        chk("t2_seq_done", cnt_seq, 1);
        chk("t2_starts", cnt_start, 0);
        chk("t2_busy_cycles", cnt_busy, 1);

        // append while running
        clr_stats();
        cq = {4'h1, 4'h2}; load(pack(cq)); wait_idle("t3_load");
        pulse_run(); wait_log(1); @(negedge clock);
        cq = {4'h3, 4'h4}; load(pack(cq));
        wait_idle("t3_run");
        eq = {4'h1, 4'h2, 4'h3, 4'h4};
        chk_log("t3_codes", eq);
        chk("t3_curr_step", curr_step, 4);
        chk("t3_seq_done", cnt_seq, 1);

        // overflow with DEPTH=4
        clr_stats();
        cq = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6}; load(pack(cq)); wait_idle("t4_load");
        chk("t4_num_moves", num_moves, 4);
        chk("t4_overflow", overflow, 1);
        pulse_run(); wait_idle("t4_run");
        eq = {4'h1, 4'h2, 4'h3, 4'h4};
        chk_log("t4_codes", eq);

        // abort in WAIT_DONE of move 2 of 5
        clr_stats();
        cq = {4'h7, 4'h8, 4'h9, 4'hA}; load(pack(cq)); wait_idle("t5_load");
        pulse_run(); wait_log(1);
        cq = {4'hB}; load(pack(cq));
        wait_log(2); @(negedge clock);
        abort = 1'b1; @(negedge clock); abort = 1'b0;
        cyc(10);
        chk("t5_starts", log_q.size(), 2);
        chk("t5_aborted", cnt_abt, 1);
        chk("t5_seq_done", cnt_seq, 0);
        chk("t5_num_moves", num_moves, 0);
        clr_stats();
        pulse_run(); wait_idle("t5_rerun"); cyc(2);
        chk("t5_rerun_seq", cnt_seq, 1);
        chk("t5_rerun_starts", cnt_start, 0);

        // abort together with load_valid: load refused
        cq = {4'h5}; load_seq = pack(cq); load_valid = 1'b1; abort = 1'b1;
        @(negedge clock); load_valid = 1'b0; abort = 1'b0;
        cyc(3);
        chk("t6_num_moves", num_moves, 0);

        // pointer wrap: 3*DEPTH pushes and pops
        clr_stats(); eq.delete();
        for (int r = 0; r < 4; r++) begin
            cq.delete();
            for (int j = 1; j <= 3; j++) begin
                cq.push_back(MW'(3*r + j)); eq.push_back(MW'(3*r + j));
            end
            load(pack(cq)); wait_idle("t7_load");
            pulse_run(); wait_idle("t7_run");
        end
        chk_log("t7_wrap", eq);

        // asynchronous reset mid-unpack
        w = '0;
        for (int i = 0; i < SM; i++) w[i*MW +: MW] = MW'($urandom_range(1, 15));
        load(w); cyc(5);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("rst_unpack");
        @(negedge clock); @(negedge clock); reset_n = 1'b1;
        cyc(2);

        // asynchronous reset mid-run
        cq = {4'h2, 4'h3, 4'h4}; load(pack(cq)); wait_idle("t8_load");
        clr_stats(); pulse_run(); wait_log(1);
        #3 reset_n = 1'b0;
        #1 chk_reset_outputs("rst_run");
        @(negedge clock); @(negedge clock); reset_n = 1'b1;
        cyc(2);
        clr_stats();
        cq = {4'h6, 4'h7}; load(pack(cq)); wait_idle("t9_load");
        pulse_run(); wait_idle("t9_run");
        eq = {4'h6, 4'h7};
        chk_log("t9_codes", eq);
        chk("t9_curr_step", curr_step, 2);

        // randomized traffic, model checked every cycle
        exec_dly = 0;
        for (int t = 0; t < 3000; t++) begin
            w = '0;
            repeat ($urandom_range(0, 5)) w[$urandom_range(0, SM-1)*MW +: MW] = MW'($urandom);
            load_seq   = w;
            load_valid = ($urandom_range(0, 7) == 0);
            run        = ($urandom_range(0, 11) == 0);
            abort      = ($urandom_range(0, 79) == 0);
            @(negedge clock);
        end
        load_valid = 1'b0; run = 1'b0; abort = 1'b0;
        wait_idle("rand_end");
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
